// File: rtl/obi_mem_arbiter.sv
// Shares one OBI memory port between instruction-fetch and data requesters,
// with round-robin address arbitration and in-order response routing by ID FIFO.
//
// state    | meaning
// IDLE     | no held request; arbitrate fresh requests each cycle
// WAIT_GNT | a request was presented but not granted; selection is locked
module obi_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    instr_req_i,
    output logic                    instr_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,

    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,

    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

    output logic [2:0]              outstanding_o,
    output logic                    protocol_err_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);
    localparam logic SIDE_INSTR = 1'b0;
    localparam logic SIDE_DATA  = 1'b1;

    typedef enum logic {IDLE, WAIT_GNT} state_t;

    state_t             state, state_next;
    logic               sel, last;
    logic               cur_sel, winner;
    logic [2:0]         count;
    logic               full, push, pop, head;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               id_mem [MAX_OUTSTANDING];
    logic               err;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full = (count == MAX_CNT);

    // Lone requester wins; on a tie the side that did not win last time goes.
    always_comb begin
        winner = SIDE_INSTR;
        if (instr_req_i && data_req_i) winner = ~last;
        else if (data_req_i)           winner = SIDE_DATA;
    end

    always_comb begin
        state_next = state;
        mem_req_o  = 1'b0;
        cur_sel    = sel;
        case (state)
            IDLE: begin
                cur_sel = winner;
                if (!full && (instr_req_i || data_req_i)) begin
                    mem_req_o = 1'b1;
                    if (!mem_gnt_i) state_next = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = {BE_W{1'b1}};
        mem_wdata_o = '0;
        if (cur_sel == SIDE_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    assign push        = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = push & (cur_sel == SIDE_INSTR);
    assign data_gnt_o  = push & (cur_sel == SIDE_DATA);

    // A response only pops entries that existed before this cycle's push.
    assign pop  = mem_rvalid_i & (count != 3'd0);
    assign head = id_mem[rd_ptr];

    assign instr_rvalid_o = pop & (head == SIDE_INSTR);
    assign data_rvalid_o  = pop & (head == SIDE_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign outstanding_o  = count;
    assign protocol_err_o = err;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel    <= SIDE_INSTR;
            last   <= SIDE_INSTR;
            count  <= 3'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            err    <= 1'b0;
        end else begin
            if (state == IDLE && mem_req_o && !mem_gnt_i) sel <= winner;
            if (push) begin
                last   <= cur_sel;
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      count <= count + 3'd1;
            else if (pop && !push) count <= count - 3'd1;
            if (mem_rvalid_i && count == 3'd0) err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) id_mem[wr_ptr] <= cur_sel;
    end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed-vector bench for obi_mem_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, state updates land on the following rising edge.
module tb_obi_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic [3:0]  data_be_i;
    logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;
    logic [2:0]  outstanding_o;
    logic        protocol_err_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    obi_mem_arbiter #(.MAX_OUTSTANDING(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic quiet_inputs();
        instr_req_i  = 1'b0; instr_addr_i = 32'h0;
        data_req_i   = 1'b0; data_addr_i  = 32'h0;
        data_we_i    = 1'b0; data_be_i    = 4'h0; data_wdata_i = 32'h0;
        mem_gnt_i    = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i  = 32'h0;
    endtask

    // Advance to the next falling edge (inputs for the new cycle go on here).
    task automatic next_cyc();
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1;
        quiet_inputs();
        repeat (2) @(posedge clk_i);
        next_cyc(); rst_i = 1'b0; #1;
        chk("rst_outstanding", 32'(outstanding_o), 32'd0);
        chk("rst_err",         32'(protocol_err_o), 32'd0);
        chk("rst_mem_req",     32'(mem_req_o), 32'd0);
        chk("rst_gnts",        32'({instr_gnt_o, data_gnt_o}), 32'd0);
        chk("rst_rvalids",     32'({instr_rvalid_o, data_rvalid_o}), 32'd0);

        // single fetch
        next_cyc(); instr_req_i = 1'b1; instr_addr_i = 32'h0002_0000; mem_gnt_i = 1'b1; #1;
        chk("f_instr_gnt", 32'(instr_gnt_o), 32'd1);
        chk("f_data_gnt",  32'(data_gnt_o), 32'd0);
        chk("f_addr",      mem_addr_o, 32'h0002_0000);
        chk("f_we",        32'(mem_we_o), 32'd0);
        chk("f_be",        32'(mem_be_o), 32'hF);
        next_cyc(); quiet_inputs(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; #1;
        chk("f_outst1",     32'(outstanding_o), 32'd1);
        chk("f_instr_rv",   32'(instr_rvalid_o), 32'd1);
        chk("f_instr_rdat", instr_rdata_o, 32'hDEAD_BEEF);
        chk("f_data_rv",    32'(data_rvalid_o), 32'd0);
        next_cyc(); quiet_inputs(); #1;
        chk("f_outst0", 32'(outstanding_o), 32'd0);

        // round robin, last=instr so data goes first
        next_cyc();
        instr_req_i = 1'b1; instr_addr_i = 32'h100;
        data_req_i = 1'b1; data_addr_i = 32'h200; data_we_i = 1'b1; data_be_i = 4'h3;
        data_wdata_i = 32'h55; mem_gnt_i = 1'b1; #1;
        chk("rr0_dgnt", 32'(data_gnt_o), 32'd1);
        chk("rr0_ignt", 32'(instr_gnt_o), 32'd0);
        chk("rr0_addr", mem_addr_o, 32'h200);
        chk("rr0_we",   32'(mem_we_o), 32'd1);
        chk("rr0_be",   32'(mem_be_o), 32'h3);
        chk("rr0_wd",   mem_wdata_o, 32'h55);
        next_cyc(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA1; #1;
        chk("rr1_ignt", 32'(instr_gnt_o), 32'd1);
        chk("rr1_addr", mem_addr_o, 32'h100);
        chk("rr1_wd",   mem_wdata_o, 32'h0);
        chk("rr1_drv",  32'(data_rvalid_o), 32'd1);
        chk("rr1_irv",  32'(instr_rvalid_o), 32'd0);
        next_cyc(); mem_rdata_i = 32'hA2; #1;
        chk("rr2_dgnt", 32'(data_gnt_o), 32'd1);
        chk("rr2_irv",  32'(instr_rvalid_o), 32'd1);
        chk("rr2_drv",  32'(data_rvalid_o), 32'd0);
        next_cyc(); mem_rdata_i = 32'hA3; #1;
        chk("rr3_ignt", 32'(instr_gnt_o), 32'd1);
        chk("rr3_drv",  32'(data_rvalid_o), 32'd1);
        chk("rr3_drd",  data_rdata_o, 32'hA3);
        next_cyc(); quiet_inputs(); mem_rvalid_i = 1'b1; #1;
        chk("rr4_irv",  32'(instr_rvalid_o), 32'd1);
        next_cyc(); quiet_inputs(); #1;
        chk("rr_outst0", 32'(outstanding_o), 32'd0);

        // held selection while waiting for grant
        next_cyc(); instr_req_i = 1'b1; instr_addr_i = 32'h300; #1;
        chk("wg0_req",  32'(mem_req_o), 32'd1);
        chk("wg0_addr", mem_addr_o, 32'h300);
        chk("wg0_ignt", 32'(instr_gnt_o), 32'd0);
        for (int i = 1; i <= 2; i++) begin
            next_cyc(); data_req_i = 1'b1; data_addr_i = 32'h400; #1;
            chk("wg_addr_held", mem_addr_o, 32'h300);
            chk("wg_dgnt_low",  32'(data_gnt_o), 32'd0);
        end
        next_cyc(); mem_gnt_i = 1'b1; #1;
        chk("wg3_ignt", 32'(instr_gnt_o), 32'd1);
        chk("wg3_dgnt", 32'(data_gnt_o), 32'd0);
        chk("wg3_addr", mem_addr_o, 32'h300);
        next_cyc(); instr_req_i = 1'b0; #1;
        chk("wg4_dgnt", 32'(data_gnt_o), 32'd1);
        chk("wg4_addr", mem_addr_o, 32'h400);
        next_cyc(); quiet_inputs(); mem_rvalid_i = 1'b1; #1;
        chk("wg5_irv", 32'(instr_rvalid_o), 32'd1);
        next_cyc(); quiet_inputs(); mem_rvalid_i = 1'b1; #1;
        chk("wg6_drv", 32'(data_rvalid_o), 32'd1);

        // full at MAX_OUTSTANDING=2
        next_cyc(); quiet_inputs(); instr_req_i = 1'b1; instr_addr_i = 32'h500; mem_gnt_i = 1'b1; #1;
        chk("fu0_ignt", 32'(instr_gnt_o), 32'd1);
        next_cyc(); instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h600; #1;
        chk("fu1_dgnt", 32'(data_gnt_o), 32'd1);
        next_cyc(); data_req_i = 1'b0; instr_req_i = 1'b1; #1;
        chk("fu2_outst", 32'(outstanding_o), 32'd2);
        chk("fu2_req",   32'(mem_req_o), 32'd0);
        chk("fu2_ignt",  32'(instr_gnt_o), 32'd0);
        next_cyc(); mem_rvalid_i = 1'b1; #1;
        chk("fu3_req", 32'(mem_req_o), 32'd0);
        chk("fu3_irv", 32'(instr_rvalid_o), 32'd1);
        next_cyc(); mem_rvalid_i = 1'b0; #1;
        chk("fu4_outst", 32'(outstanding_o), 32'd1);
        chk("fu4_ignt",  32'(instr_gnt_o), 32'd1);
        next_cyc(); quiet_inputs(); mem_rvalid_i = 1'b1; #1;
        chk("fu5_outst", 32'(outstanding_o), 32'd2);
        chk("fu5_drv",   32'(data_rvalid_o), 32'd1);
        next_cyc(); quiet_inputs(); mem_rvalid_i = 1'b1; #1;
        chk("fu6_irv", 32'(instr_rvalid_o), 32'd1);

        // accept and response together
        next_cyc(); quiet_inputs(); data_req_i = 1'b1; data_addr_i = 32'h700; mem_gnt_i = 1'b1; #1;
        chk("sim0_outst", 32'(outstanding_o), 32'd0);
        chk("sim0_dgnt",  32'(data_gnt_o), 32'd1);
        next_cyc(); data_req_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h800; mem_rvalid_i = 1'b1; #1;
        chk("sim1_ignt", 32'(instr_gnt_o), 32'd1);
        chk("sim1_drv",  32'(data_rvalid_o), 32'd1);
        chk("sim1_irv",  32'(instr_rvalid_o), 32'd0);
        next_cyc(); quiet_inputs(); mem_rvalid_i = 1'b1; #1;
        chk("sim2_outst", 32'(outstanding_o), 32'd1);
        chk("sim2_irv",   32'(instr_rvalid_o), 32'd1);
        next_cyc(); quiet_inputs(); #1;
        chk("sim3_outst", 32'(outstanding_o), 32'd0);

        // spurious response
        next_cyc(); quiet_inputs(); mem_rvalid_i = 1'b1; #1;
        chk("sp_rvalids", 32'({instr_rvalid_o, data_rvalid_o}), 32'd0);
        next_cyc(); quiet_inputs(); #1;
        chk("sp_err",   32'(protocol_err_o), 32'd1);
        chk("sp_outst", 32'(outstanding_o), 32'd0);

        // reset during WAIT_GNT with one transaction outstanding
        next_cyc(); data_req_i = 1'b1; data_addr_i = 32'h900; mem_gnt_i = 1'b1; #1;
        chk("rw0_dgnt", 32'(data_gnt_o), 32'd1);
        next_cyc(); quiet_inputs(); instr_req_i = 1'b1; instr_addr_i = 32'h300; #1;
        chk("rw1_req", 32'(mem_req_o), 32'd1);
        next_cyc(); rst_i = 1'b1; #1;
        next_cyc(); rst_i = 1'b0; instr_req_i = 1'b0; mem_rvalid_i = 1'b1; #1;
        chk("rw3_outst",   32'(outstanding_o), 32'd0);
        chk("rw3_err",     32'(protocol_err_o), 32'd0);
        chk("rw3_req",     32'(mem_req_o), 32'd0);
        chk("rw3_rvalids", 32'({instr_rvalid_o, data_rvalid_o}), 32'd0);
        next_cyc(); quiet_inputs(); instr_addr_i = 32'h300;
        data_req_i = 1'b1; data_addr_i = 32'h400; mem_gnt_i = 1'b1; #1;
        chk("rw4_addr", mem_addr_o, 32'h400);
        chk("rw4_dgnt", 32'(data_gnt_o), 32'd1);
        chk("rw4_err",  32'(protocol_err_o), 32'd1);

        next_cyc(); quiet_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
